ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the CPU load/store unit (primary) and the IO/debug loader (secondary).
- Per request it:
  - generates the word address, byte enables and replicated write data;
  - sequences the 1-cycle RAM read latency;
  - aligns and zero/sign-extends load data.
- Sits between the memory stage / IO bridge and the RAM macro.

Parameters:
ADDR_W, 16, byte-address width of both request ports
STARVE_LIM, 4, consecutive CPU grants tolerated while IO is pending before IO is forced

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  CPU request accepted this cycle when valid&ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address
cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
cpu_unsigned  in  1  load zero-extend when 1
cpu_wdata  in  32  store data, LSB-justified
cpu_rsp_valid  out  1  one-cycle response pulse
cpu_rsp_rdata  out  32  aligned/extended load data (0 for stores/errors)
cpu_rsp_err  out  1  misaligned or illegal size
io_req_valid, io_req_ready, io_we, io_addr, io_size, io_unsigned, io_wdata, io_rsp_valid, io_rsp_rdata, io_rsp_err  same directions/widths/meaning as cpu_*
ram_en  out  1  RAM access strobe
ram_we  out  4  byte write enables
ram_addr  out  ADDR_W-2  word address
ram_wdata  out  32  write data
ram_rdata  in  32  read data, valid the cycle after ram_en with ram_we=0

Behaviour:
- Reset: state IDLE; all ram_* and rsp_* outputs 0; starve counter 0; both *_req_ready forced 0 while rst_n low.
- Any in-flight access is dropped on reset: no response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT.
- Only IDLE accepts requests. ready = (state==IDLE) & granted port.
- Arbitration in IDLE:
  - CPU wins over IO.
  - Exception: IO wins if io_req_valid and starve_cnt==STARVE_LIM.
  - Only one ready is ever high.
- Starve counter:
  - increments on each CPU accept while io_req_valid is high, saturating at STARVE_LIM;
  - clears on IO accept, or in any cycle io_req_valid is low.
- Alignment check at accept (T):
  - Error conditions: size==11; half with addr[0]=1; word with addr[1:0]!=0.
  - On error: response pulse at T+1 with err=1, rdata=0; no RAM access; stay IDLE.
- Legal accept at T → ISSUE at T+1. Registered RAM command is driven during T+1:
  - ram_en=1; ram_addr=addr[ADDR_W-1:2].
  - Store byte: ram_we=4'b0001<<addr[1:0]; wdata = byte replicated x4.
  - Store half: ram_we=4'b0011<<addr[1:0]; wdata = half replicated x2.
  - Store word: ram_we=4'b1111; wdata unchanged.
  - Load: ram_we=0.
- Store: ISSUE→IDLE; rsp_valid pulse at T+2 with rdata=0, err=0. Next accept possible at T+2.
- Load: ISSUE→WAIT. In WAIT:
  - ram_rdata is shifted right by 8*addr[1:0];
  - byte/half loads are zero- or sign-extended per the latched unsigned flag;
  - the result is registered.
  - rsp_valid pulse at T+3; WAIT→IDLE.
- Latched per transaction: owner, we, addr[1:0], size, unsigned.
- The response goes only to the owner's rsp_* port; the other port's rsp_valid stays 0.
- ram_en is 0 in every cycle not in ISSUE.
- Requester may hold or change valid/fields freely while not ready; nothing is sampled without valid&ready.

Decomposition:
- Package ram_arb_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - state enum {IDLE, ISSUE, WAIT};
  - owner encoding OWN_CPU/OWN_IO;
  - default STARVE_LIM.
- One combinational sub-module, ram_load_align:
  - inputs: rdata, addr[1:0], size, unsigned;
  - output: 32-bit aligned and extended result.
  - Instantiated in the WAIT datapath.
- Byte-enable and replication logic stays inline.

Test Plan:
- RAM word 0x10 = 0x8844C2F1; CPU load byte signed, addr 0x11 → cpu_rsp_valid at T+3, rdata 0xFFFFFFC2, err 0.
- Same word; CPU load half unsigned, addr 0x12 → rdata 0x00008844. Load word, addr 0x10 → rdata 0x8844C2F1.
- CPU store byte, addr 0x13, wdata 0x000000AB → at T+1: ram_we 4'b1000, ram_wdata 0xABABABAB, ram_addr 0x4. rsp at T+2. Readback word = 0xAB44C2F1.
- IO load word, addr 0x12 → io_rsp_valid at T+1 with err=1; ram_en never asserts. Size 11 behaves the same.
- Both ports valid continuously with stores, STARVE_LIM=4 → accept order C,C,C,C,I,C,C,C,C,I. Every response reaches only its owner.
- CPU load accepted, rst_n pulled low during WAIT → no rsp_valid on either port. After release: IDLE, ready=1 for a waiting CPU request, all outputs 0 until the next accept.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM access arbiter.
//   - access size encodings (byte / half / word; 2'b11 is illegal)
//   - FSM state and transaction-owner encodings
//   - per-transaction context latched at accept
//   - default starvation limit
//   - alignment check helper
package ram_arb_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int STARVE_LIM_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_t;

  // Context needed after accept: who gets the response, and how to
  // align/extend the read data.
  typedef struct packed {
    owner_t     owner;
    logic       we;
    logic [1:0] lo;
    logic [1:0] size;
    logic       uns;
  } txn_t;

  // True when the access cannot be performed: illegal size, or a
  // half/word that is not naturally aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_access_arbiter_load_align.sv
// Combinational load alignment for the arbiter's WAIT datapath.
// Ports:
//   rdata  - raw 32-bit RAM word
//   lo     - byte offset addr[1:0] of the load
//   size   - SZ_B / SZ_H / SZ_W
//   uns    - 1 = zero-extend, 0 = sign-extend (byte/half only)
//   result - LSB-justified, extended load value
module ram_load_align
  import ram_arb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {lo, 3'b000};
    case (size)
      SZ_B:    result = uns ? {24'h0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    result = uns ? {16'h0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU load/store
// unit (primary) and the IO/debug loader (secondary).
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   cpu_req_* / cpu_rsp_*      - CPU request (valid/ready) and response pulse
//   io_req_*  / io_rsp_*       - IO request and response, same meaning
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata       - RAM macro interface (1-cycle read latency)
// A request is accepted only in IDLE. Misaligned/illegal requests respond
// one cycle after accept with err=1 and never touch the RAM. Legal stores
// respond two cycles after accept, loads three.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_rdata,
  output logic              cpu_rsp_err,

  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [1:0]        io_size,
  input  logic              io_unsigned,
  input  logic [31:0]       io_wdata,
  output logic              io_rsp_valid,
  output logic [31:0]       io_rsp_rdata,
  output logic              io_rsp_err,

  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int               CNT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  txn_t              txn;

  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  owner_t            rsp_owner;

  logic              io_force;
  logic              grant_cpu, grant_io;
  logic              acc_cpu, acc_io, accept, acc_err;
  txn_t              acc_txn;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        cmd_we;
  logic [31:0]       cmd_wdata;
  logic [31:0]       load_data;

  // Arbitration, accept decode and next state.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;

    // IO only beats a valid CPU request once it has been starved enough.
    io_force  = io_req_valid && (starve_cnt == CNT_MAX);
    grant_io  = io_req_valid && (!cpu_req_valid || io_force);
    grant_cpu = cpu_req_valid && !grant_io;

    cpu_req_ready = rst_n && (state == IDLE) && grant_cpu;
    io_req_ready  = rst_n && (state == IDLE) && grant_io;

    acc_cpu = cpu_req_valid && cpu_req_ready;
    acc_io  = io_req_valid && io_req_ready;
    accept  = acc_cpu || acc_io;

    acc_txn.owner = grant_io ? OWN_IO : OWN_CPU;
    acc_txn.we    = grant_io ? io_we        : cpu_we;
    acc_txn.size  = grant_io ? io_size      : cpu_size;
    acc_txn.uns   = grant_io ? io_unsigned  : cpu_unsigned;
    acc_addr      = grant_io ? io_addr      : cpu_addr;
    acc_wdata     = grant_io ? io_wdata     : cpu_wdata;
    acc_txn.lo    = acc_addr[1:0];
    acc_err       = is_misaligned(acc_txn.size, acc_txn.lo);

    // Byte lanes and replicated write data for the RAM command.
    case (acc_txn.size)
      SZ_B: begin
        cmd_we    = 4'b0001 << acc_txn.lo;
        cmd_wdata = {4{acc_wdata[7:0]}};
      end
      SZ_H: begin
        cmd_we    = 4'b0011 << acc_txn.lo;
        cmd_wdata = {2{acc_wdata[15:0]}};
      end
      default: begin
        cmd_we    = 4'b1111;
        cmd_wdata = acc_wdata;
      end
    endcase
    if (!acc_txn.we) begin
      cmd_we    = 4'b0000;
      cmd_wdata = 32'h0;
    end

    case (state)
      IDLE:    if (accept && !acc_err) state_nxt = ISSUE;
      ISSUE:   state_nxt = txn.we ? IDLE : WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Starvation counter: counts CPU wins while IO is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!io_req_valid || acc_io) begin
      starve_cnt <= '0;
    end else if (acc_cpu && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  ram_load_align u_load_align (
    .rdata  (ram_rdata),
    .lo     (txn.lo),
    .size   (txn.size),
    .uns    (txn.uns),
    .result (load_data)
  );

  // RAM command and response registers. Command and response strobes are
  // single-cycle: they default to zero every cycle and are set only by the
  // event that produces them, so ram_en is high exactly while in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn       <= '0;
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_owner <= OWN_CPU;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;

      if (accept) begin
        txn <= acc_txn;
        if (acc_err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_owner <= acc_txn.owner;
        end else begin
          ram_en    <= 1'b1;
          ram_we    <= cmd_we;
          ram_addr  <= acc_addr[ADDR_W-1:2];
          ram_wdata <= cmd_wdata;
        end
      end

      case (state)
        ISSUE: begin
          if (txn.we) begin
            rsp_valid <= 1'b1;
            rsp_owner <= txn.owner;
          end
        end
        WAIT: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
          rsp_owner <= txn.owner;
        end
        default: ;
      endcase
    end
  end

  // Response steering: only the owner's port ever sees a response.
  always_comb begin
    cpu_rsp_valid = rsp_valid && (rsp_owner == OWN_CPU);
    cpu_rsp_err   = rsp_err   && (rsp_owner == OWN_CPU);
    cpu_rsp_rdata = (rsp_owner == OWN_CPU) ? rsp_rdata : 32'h0;
    io_rsp_valid  = rsp_valid && (rsp_owner == OWN_IO);
    io_rsp_err    = rsp_err   && (rsp_owner == OWN_IO);
    io_rsp_rdata  = (rsp_owner == OWN_IO) ? rsp_rdata : 32'h0;
  end

endmodule
